// File: rtl/pwm_vnb.sv
// 4-bit fixed-frequency PWM generator for the BLDC gate-drive path.
// A free-running 4-bit counter sets a 16-clock period. The duty word is
// double-buffered into a shadow register at the wrap edge, so no period
// ever sees a partial duty change.
module pwm_vnb (
  input  logic CLK,
  input  logic RST_N,
  input  logic CE,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  output logic q0,
  output logic q1,
  output logic q2,
  output logic q3,
  output logic PWM,
  output logic Chk
);

  logic [3:0] cnt_q, cnt_d;
  logic [3:0] duty_q, duty_d;
  logic [3:0] duty_in;
  logic       term;

  assign duty_in = {D3, D2, D1, D0};
  assign term    = (cnt_q == 4'hF);

  // Next state: count when enabled, and reload the duty shadow on the wrap edge.
  always_comb begin
    cnt_d  = cnt_q;
    duty_d = duty_q;
    if (CE) begin
      cnt_d = cnt_q + 4'd1;
      if (term) begin
        duty_d = duty_in;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= 4'd0;
      duty_q <= 4'd0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
    end
  end

  // Outputs decode registered state only; duty 15 leaves one low count per period.
  always_comb begin
    {q3, q2, q1, q0} = cnt_q;
    PWM              = (cnt_q < duty_q);
    Chk              = term;
  end

endmodule

// File: tb/tb_pwm_vnb.sv
// Self-checking bench for pwm_vnb: a period/phase model checked every cycle,
// plus directed literal expectations at the interesting points.
module tb_pwm_vnb;

  logic CLK;
  logic RST_N;
  logic CE;
  logic D0, D1, D2, D3;
  logic q0, q1, q2, q3;
  logic PWM;
  logic Chk;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_vnb dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE    (CE),
    .D0    (D0),
    .D1    (D1),
    .D2    (D2),
    .D3    (D3),
    .q0    (q0),
    .q1    (q1),
    .q2    (q2),
    .q3    (q3),
    .PWM   (PWM),
    .Chk   (Chk)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: count enabled clocks since reset; phase = ticks mod 16, and the
  // duty for a period is whatever D was when that period began.
  int ticks   = 0;
  int cur_duty = 0;

  always @(posedge CLK or negedge RST_N) begin
    if (RST_N !== 1'b1) begin
      ticks    = 0;
      cur_duty = 0;
    end else if (CE === 1'b1) begin
      ticks = ticks + 1;
      if (ticks % 16 == 0) cur_duty = int'({D3, D2, D1, D0});
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge CLK) begin
    int ph;
    ph = ticks % 16;
    check("model_cnt", int'({q3, q2, q1, q0}), ph);
    check("model_pwm", int'(PWM), (ph < cur_duty) ? 1 : 0);
    check("model_chk", int'(Chk), (ph == 15) ? 1 : 0);
  end

  task automatic set_d(input logic [3:0] v);
    {D3, D2, D1, D0} = v;
  endtask

  // Advance n rising edges, then settle 2ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic lit(input string name, input int cnt, input int pwm, input int chk);
    check({name, "_cnt"}, int'({q3, q2, q1, q0}), cnt);
    check({name, "_pwm"}, int'(PWM), pwm);
    check({name, "_chk"}, int'(Chk), chk);
  endtask

  initial begin
    RST_N = 1'b0;
    CE    = 1'b1;
    set_d(4'b1011);

    // Reset held for three clocks.
    tick(3);
    lit("reset_hold", 0, 0, 0);
    RST_N = 1'b1;

    // First period: duty shadow is 0.
    tick(15);
    lit("p0_cnt15", 15, 0, 1);
    tick(1);
    lit("p1_cnt0", 0, 1, 0);
    tick(10);
    lit("p1_cnt10", 10, 1, 0);
    tick(1);
    lit("p1_cnt11", 11, 0, 0);

    // Mid-period duty change only lands in the next period.
    tick(5);
    lit("p2_cnt0", 0, 1, 0);
    tick(5);
    set_d(4'b0011);
    tick(5);
    lit("p2_cnt10", 10, 1, 0);
    tick(1);
    lit("p2_cnt11", 11, 0, 0);
    tick(5);
    lit("p3_cnt0", 0, 1, 0);
    tick(2);
    lit("p3_cnt2", 2, 1, 0);
    tick(1);
    lit("p3_cnt3", 3, 0, 0);

    // Duty 0, then duty 15.
    set_d(4'b0000);
    tick(13);
    lit("p4_cnt0", 0, 0, 0);
    set_d(4'b1111);
    tick(16);
    lit("p5_cnt0", 0, 1, 0);
    tick(14);
    lit("p5_cnt14", 14, 1, 0);
    tick(1);
    lit("p5_cnt15", 15, 0, 1);

    // CE gating at cnt 7.
    set_d(4'b1011);
    tick(8);
    lit("p6_cnt7", 7, 1, 0);
    CE = 1'b0;
    tick(10);
    lit("ce_frozen", 7, 1, 0);
    CE = 1'b1;
    tick(1);
    lit("ce_resume", 8, 1, 0);
    tick(1);

    // Asynchronous reset mid-cycle at cnt 9.
    #1;
    RST_N = 1'b0;
    #1;
    lit("async_clr", 0, 0, 0);
    tick(1);
    RST_N = 1'b1;
    tick(15);
    lit("rp0_cnt15", 15, 0, 1);
    tick(1);
    lit("rp1_cnt0", 0, 1, 0);
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
